lock_attempt_controller: RTL and testbench

LOCK_ATTEMPT_CONTROLLER -- requirements
Module: lock_attempt_controller

---
 rtl/lock_pkg.sv | 32 +++
 rtl/lock_cycle_timer.sv | 28 ++
 rtl/lock_attempt_controller.sv | 163 ++++++++++++++++
 tb/tb_lock_attempt_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared state encoding, default parameters and sizing helper for the code lock.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCK,
        ST_FAIL,
        ST_LOCKOUT
    } lock_state_e;

    localparam int unsigned DEF_CODE_LEN       = 4;
    localparam logic [3:0]  DEF_CODE           = 4'b1010;
    localparam int unsigned DEF_MAX_FAIL       = 3;
    localparam int unsigned DEF_UNLOCK_CYCLES  = 8;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 16;
    localparam int unsigned DEF_ENTRY_TIMEOUT  = 32;

    // Fail counter is two bits wide and saturates here.
    localparam logic [1:0]  FAIL_SAT           = 2'd3;

    // Largest of three interval lengths; sizes the shared timer.
    function automatic int unsigned max_of3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_cycle_timer.sv
// Loadable down-counter; done_c is high while the count has reached zero.
module lock_cycle_timer
    import lock_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             done_c
);

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/lock_attempt_controller.sv
// Serial code-entry lock: collects CODE_LEN bits, unlocks on match, locks out
// after MAX_FAIL consecutive failures. One shared timer covers the entry
// timeout, the unlock window and the lockout window.
module lock_attempt_controller
    import lock_pkg::*;
#(
    parameter int unsigned          CODE_LEN       = DEF_CODE_LEN,
    parameter logic [CODE_LEN-1:0]  CODE           = CODE_LEN'(DEF_CODE),
    parameter int unsigned          MAX_FAIL       = DEF_MAX_FAIL,
    parameter int unsigned          UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int unsigned          LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned          ENTRY_TIMEOUT  = DEF_ENTRY_TIMEOUT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       bit_ready,
    output logic       unlocked,
    output logic       fail_pulse,
    output logic       alarm,
    output logic [1:0] fail_count
);

    localparam int unsigned TIMER_W =
        $clog2(max_of3(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT) + 1);
    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);

    lock_state_e         state_q, state_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]          fail_q, fail_d;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_value;
    logic [TIMER_W-1:0]  timer_count;
    logic                timer_done_c;
    logic                accept_c;
    logic                match_c;
    logic [1:0]          fail_inc_c;

    assign accept_c   = bit_valid && bit_ready;
    assign match_c    = (bit_cnt_q == CNT_W'(CODE_LEN)) && (code_q == CODE);
    assign fail_inc_c = (fail_q == FAIL_SAT) ? FAIL_SAT : fail_q + 2'd1;

    lock_cycle_timer #(
        .WIDTH      (TIMER_W)
    ) u_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (timer_load),
        .load_value (timer_value),
        .count      (timer_count),
        .done_c     (timer_done_c)
    );

    // State, code shift register, bit count and consecutive-fail register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            bit_cnt_q <= '0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            bit_cnt_q <= bit_cnt_d;
            fail_q    <= fail_d;
        end
    end

    // Next-state, datapath updates and timer loads.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        bit_cnt_d   = bit_cnt_q;
        fail_d      = fail_q;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    code_d      = CODE_LEN'({code_q, bit_in});
                    bit_cnt_d   = CNT_W'(1);
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(ENTRY_TIMEOUT - 1);
                    state_d     = (CODE_LEN == 1) ? ST_CHECK : ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (accept_c) begin
                    code_d      = CODE_LEN'({code_q, bit_in});
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(ENTRY_TIMEOUT - 1);
                    if (bit_cnt_q == CNT_W'(CODE_LEN - 1)) begin
                        state_d = ST_CHECK;
                    end
                end else if (timer_done_c) begin
                    // Short bit count makes this attempt a mismatch.
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Clearing here leaves code and count zero on arrival in IDLE.
                code_d     = '0;
                bit_cnt_d  = '0;
                timer_load = 1'b1;
                if (match_c) begin
                    fail_d      = '0;
                    timer_value = TIMER_W'(UNLOCK_CYCLES - 1);
                    state_d     = ST_UNLOCK;
                end else begin
                    fail_d = fail_inc_c;
                    if (32'(fail_inc_c) == MAX_FAIL) begin
                        timer_value = TIMER_W'(LOCKOUT_CYCLES - 1);
                        state_d     = ST_LOCKOUT;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_UNLOCK: begin
                if (timer_done_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (timer_done_c) begin
                    fail_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs. bit_ready tracks the state it qualifies so the
    // handshake is exact; the status outputs are decoded from the current
    // state and counters, so they appear one cycle after the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bit_ready  <= 1'b1;
            unlocked   <= 1'b0;
            fail_pulse <= 1'b0;
            alarm      <= 1'b0;
            fail_count <= '0;
        end else begin
            bit_ready  <= (state_d == ST_IDLE) || (state_d == ST_ENTRY);
            unlocked   <= (state_q == ST_UNLOCK);
            alarm      <= (state_q == ST_LOCKOUT);
            fail_pulse <= (state_q == ST_FAIL) ||
                          ((state_q == ST_LOCKOUT) &&
                           (timer_count == TIMER_W'(LOCKOUT_CYCLES - 1)));
            fail_count <= fail_q;
        end
    end

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Bench for lock_attempt_controller: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against an
// event-scheduled model of the output waveforms.
module tb_lock_attempt_controller;

    localparam int         CODE_LEN = 4;
    localparam logic [3:0] CODE     = 4'b1010;
    localparam int         MAXF     = 3;
    localparam int         UNL      = 8;
    localparam int         LCK      = 16;
    localparam int         TMO      = 32;
    localparam int         NC       = 4096;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_ready;
    logic       unlocked;
    logic       fail_pulse;
    logic       alarm;
    logic [1:0] fail_count;

    always #5 Clk = ~Clk;

    lock_attempt_controller #(
        .CODE_LEN       (CODE_LEN),
        .CODE           (CODE),
        .MAX_FAIL       (MAXF),
        .UNLOCK_CYCLES  (UNL),
        .LOCKOUT_CYCLES (LCK),
        .ENTRY_TIMEOUT  (TMO)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .unlocked   (unlocked),
        .fail_pulse (fail_pulse),
        .alarm      (alarm),
        .fail_count (fail_count)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;
    bit chk_en = 1'b0;

    // Expected output values after clock edge number i (edge 0 = reset release).
    bit e_ready [NC];
    bit e_unl   [NC];
    bit e_fp    [NC];
    bit e_al    [NC];
    int e_fc    [NC];

    int nbits, val, last_acc, mfc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, k);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < NC; i++) begin
            e_ready[i] = 1'b1;
            e_unl[i]   = 1'b0;
            e_fp[i]    = 1'b0;
            e_al[i]    = 1'b0;
            e_fc[i]    = 0;
        end
        nbits = 0; val = 0; last_acc = 0; mfc = 0; k = 0;
    endtask

    task automatic set_range(input int which, input int lo, input int hi, input int v);
        for (int j = lo; j <= hi && j < NC; j++) begin
            case (which)
                0: e_ready[j] = v[0];
                1: e_unl[j]   = v[0];
                2: e_al[j]    = v[0];
                default: e_fc[j] = v;
            endcase
        end
    endtask

    // Attempt judged at edge f: schedule the resulting output waveforms.
    task automatic finalize(input int f, input bit m);
        int nf;
        nbits = 0;
        val   = 0;
        if (m) begin
            mfc = 0;
            set_range(0, f, f + UNL, 0);
            set_range(1, f + 2, f + UNL + 1, 1);
            set_range(3, f + 2, NC - 1, 0);
        end else begin
            nf  = (mfc + 1 > 3) ? 3 : mfc + 1;
            mfc = nf;
            if (f + 2 < NC) e_fp[f + 2] = 1'b1;
            set_range(3, f + 2, NC - 1, nf);
            if (nf < MAXF) begin
                set_range(0, f, f + 1, 0);
            end else begin
                set_range(0, f, f + LCK, 0);
                set_range(2, f + 2, f + LCK + 1, 1);
                set_range(3, f + LCK + 2, NC - 1, 0);
                mfc = 0;
            end
        end
    endtask

    // Inputs (v,b) presented at edge e.
    task automatic model_step(input int e, input bit v, input bit b);
        if (v && e_ready[e - 1]) begin
            val      = val * 2 + int'(b);
            nbits    = nbits + 1;
            last_acc = e;
            if (nbits == CODE_LEN) finalize(e, val == int'(CODE));
        end else if (nbits > 0 && (e - last_acc) == TMO) begin
            finalize(e, 1'b0);
        end
    endtask

    task automatic step(input bit v, input bit b);
        bit_valid = v;
        bit_in    = b;
        model_step(k + 1, v, b);
        @(posedge Clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        chk_en    = 1'b0;
        bit_valid = 1'b0;
        Reset     = 1'b1;
        #1;
        chk("rst_unlocked", unlocked, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_fail_pulse", fail_pulse, 0);
        chk("rst_fail_count", fail_count, 0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_init();
        chk("rst_bit_ready", bit_ready, 1);
        chk_en = 1'b1;
    endtask

    task automatic send_attempt(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) begin
            int w;
            w = 0;
            while (!e_ready[k] && w < 100) begin
                step(1'b0, 1'b0);
                w++;
            end
            if (w >= 100) chk("ready_wait", 0, 1);
            step(1'b1, c[i]);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge Clk) begin
        if (chk_en && k < NC) begin
            chk("bit_ready", bit_ready, e_ready[k]);
            chk("unlocked", unlocked, e_unl[k]);
            chk("fail_pulse", fail_pulse, e_fp[k]);
            chk("alarm", alarm, e_al[k]);
            chk("fail_count", fail_count, e_fc[k]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, cnt;
        logic [3:0] code_v;
        code_v = CODE;

        // Correct code back-to-back: unlocked rises two edges later, 8 cycles.
        do_reset();
        send_attempt(4'b1010);
        a = k;
        step(1'b0, 1'b0);
        chk("unl_after_1", unlocked, 0);
        step(1'b0, 1'b0);
        chk("unl_after_2", unlocked, 1);
        chk("fc_after_unlock", fail_count, 0);
        cnt = 1;
        repeat (10) begin
            step(1'b0, 1'b0);
            cnt += int'(unlocked);
        end
        chk("unl_length", cnt, 8);

        // Wrong code: single fail pulse, count 1, ready again after FAIL.
        send_attempt(4'b1111);
        chk("ready_in_check", bit_ready, 0);
        step(1'b0, 1'b0);
        chk("ready_in_fail", bit_ready, 0);
        step(1'b0, 1'b0);
        chk("fail_pulse_1", fail_pulse, 1);
        chk("fail_count_1", fail_count, 1);
        chk("ready_after_fail", bit_ready, 1);
        chk("unl_after_fail", unlocked, 0);
        step(1'b0, 1'b0);
        chk("fail_pulse_one_cycle", fail_pulse, 0);

        // Two more wrong codes: lockout for 16 cycles, bits offered and ignored.
        send_attempt(4'b0000);
        send_attempt(4'b1100);
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            step(i <= 16, 1'($urandom_range(0, 1)));
            if (i == 2) begin
                chk("lock_fail_pulse", fail_pulse, 1);
                chk("lock_fail_count", fail_count, 3);
            end
            if (i == 18) chk("fc_after_lockout", fail_count, 0);
            cnt += int'(alarm);
        end
        chk("alarm_length", cnt, 16);

        // Two bits then silence: timeout mismatch.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 1; i <= 36; i++) begin
            step(1'b0, 1'b0);
            if (i == 31) chk("tmo_still_entry", bit_ready, 1);
            if (i == 32) chk("tmo_check", bit_ready, 0);
            if (i == 34) begin
                chk("tmo_fail_pulse", fail_pulse, 1);
                chk("tmo_fail_count", fail_count, 1);
            end
        end

        // Two wrong then correct: unlocks and clears the fail count.
        do_reset();
        send_attempt(4'b0110);
        send_attempt(4'b0001);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("fc_two_wrong", fail_count, 2);
        send_attempt(4'b1010);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("unl_after_two_wrong", unlocked, 1);
        chk("fc_cleared_by_match", fail_count, 0);
        repeat (10) step(1'b0, 1'b0);

        // Reset in lockout cycle 5 aborts it at once.
        do_reset();
        send_attempt(4'b1111);
        send_attempt(4'b1111);
        send_attempt(4'b1111);
        repeat (5) step(1'b0, 1'b0);
        chk("alarm_before_reset", alarm, 1);
        do_reset();
        repeat (3) step(1'b0, 1'b0);
        chk("idle_after_reset", bit_ready, 1);

        // Randomized traffic, biased towards the correct code, with idle gaps.
        while (k < 2500) begin
            if ($urandom_range(0, 9) == 0) begin
                repeat (34) step(1'b0, 1'b0);
            end else begin
                repeat (20) begin
                    bit v, b;
                    v = ($urandom_range(0, 9) < 7);
                    if ($urandom_range(0, 1) == 1) b = code_v[3 - nbits];
                    else b = 1'($urandom_range(0, 1));
                    step(v, b);
                end
            end
        end
        repeat (2) step(1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
